// File: rtl/plru_alloc_pkg.sv
// ============================================================================
// plru_alloc_pkg : shared state encoding and way-index width helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package plru_alloc_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SELECT = 2'd1;
   localparam state_t ST_WB     = 2'd2;
   localparam state_t ST_GRANT  = 2'd3;

   function automatic int way_idx_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/plru_victim_alloc_plru.sv
// ============================================================================
// plru : tree pseudo-LRU with evictable-mask victim search and MRU update
// Revision: 1.0
// ============================================================================
`default_nettype none

module plru
   import plru_alloc_pkg::*;
#(
   parameter int WAYS = 8,
   localparam int IW  = way_idx_w(WAYS)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            en,
   input  logic [WAYS-1:0] mask,
   output logic [IW-1:0]   victim
);

   logic [WAYS-2:0] r_tree;
   logic [WAYS-2:0] w_tree_upd;
   int              node;
   int              lo;
   int              span;
   int              half;
   logic            left_any;
   logic            right_any;
   logic            node_bit;
   logic            go_right;

   // Walk root to leaf, preferring the pointed-to subtree unless it holds no
   // evictable way. With a onehot mask the walk lands on that way, so the
   // same path flipped away from it is the MRU update.
   always_comb begin
      w_tree_upd = r_tree;
      node       = 0;
      lo         = 0;
      span       = WAYS;
      half       = 0;
      left_any   = 1'b0;
      right_any  = 1'b0;
      node_bit   = 1'b0;
      go_right   = 1'b0;
      for (int l = 0; l < IW; l++) begin
         half      = span / 2;
         left_any  = 1'b0;
         right_any = 1'b0;
         for (int w = 0; w < WAYS; w++) begin
            if (mask[w] && (w >= lo) && (w < lo + half))
               left_any = 1'b1;
            if (mask[w] && (w >= lo + half) && (w < lo + span))
               right_any = 1'b1;
         end
         node_bit = 1'b0;
         for (int n = 0; n < WAYS - 1; n++) begin
            if (n == node)
               node_bit = r_tree[n];
         end
         go_right = node_bit ? right_any : !left_any;
         for (int n = 0; n < WAYS - 1; n++) begin
            if (n == node)
               w_tree_upd[n] = !go_right;
         end
         if (go_right)
            lo = lo + half;
         node = 2 * node + (go_right ? 2 : 1);
         span = half;
      end
      victim = IW'(lo);
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         r_tree <= '0;
      else if (en)
         r_tree <= w_tree_upd;
   end

endmodule

`default_nettype wire

// File: rtl/plru_victim_alloc.sv
// ============================================================================
// plru_victim_alloc : cache-fill way allocator (free way first, else PLRU,
// optional dirty writeback). Optional macro PLRU_ALLOC_LOCK_EN enables locks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module plru_victim_alloc
   import plru_alloc_pkg::*;
#(
   parameter int WAYS = 8,
   localparam int IW  = way_idx_w(WAYS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [WAYS-1:0] set_valid,
   input  logic [WAYS-1:0] set_dirty,
   input  logic [WAYS-1:0] lock_mask,
   input  logic            touch_valid,
   input  logic [IW-1:0]   touch_way,
   output logic            wb_valid,
   output logic [IW-1:0]   wb_way,
   input  logic            wb_ready,
   output logic            gnt_valid,
   output logic [IW-1:0]   gnt_way,
   output logic            gnt_fail,
   input  logic            gnt_ready
);

   state_t          r_state;
   logic [WAYS-1:0] r_valid;
   logic [WAYS-1:0] r_dirty;
   logic [IW-1:0]   r_way;
   logic            r_fail;

   logic [WAYS-1:0] w_lock;
   logic [WAYS-1:0] w_free;
   logic [WAYS-1:0] w_plru_mask;
   logic [IW-1:0]   w_first_free;
   logic [IW-1:0]   w_plru_victim;
   logic [IW-1:0]   w_upd_way;
   logic            w_any_free;
   logic            w_all_locked;
   logic            w_plru_en;

`ifdef PLRU_ALLOC_LOCK_EN
   assign w_lock   = lock_mask;
   assign gnt_fail = r_fail;
`else
   // Locks disabled: the port is kept for interface compatibility only.
   assign w_lock   = lock_mask & {WAYS{1'b0}};
   assign gnt_fail = 1'b0;
`endif

   assign w_free       = ~r_valid & ~w_lock;
   assign w_any_free   = |w_free;
   assign w_all_locked = &w_lock;

   always_comb begin
      w_first_free = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (w_free[w])
            w_first_free = IW'(w);
      end
   end

   assign w_upd_way   = (r_state == ST_GRANT) ? r_way : touch_way;
   assign w_plru_en   = !reset &&
                        (((r_state == ST_IDLE) && touch_valid) ||
                         ((r_state == ST_GRANT) && gnt_ready && !r_fail));
   assign w_plru_mask = w_plru_en ? (WAYS'(1) << w_upd_way) : ~w_lock;

   plru #(
      .WAYS    (WAYS)
   ) u_plru (
      .clk     (clk),
      .reset_n (~reset),
      .en      (w_plru_en),
      .mask    (w_plru_mask),
      .victim  (w_plru_victim)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_valid <= '0;
         r_dirty <= '0;
         r_way   <= '0;
         r_fail  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  r_valid <= set_valid;
                  r_dirty <= set_dirty;
                  r_state <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (w_all_locked) begin
                  r_fail  <= 1'b1;
                  r_way   <= '0;
                  r_state <= ST_GRANT;
               end else if (w_any_free) begin
                  r_fail  <= 1'b0;
                  r_way   <= w_first_free;
                  r_state <= ST_GRANT;
               end else begin
                  r_fail  <= 1'b0;
                  r_way   <= w_plru_victim;
                  r_state <= (r_valid[w_plru_victim] && r_dirty[w_plru_victim])
                             ? ST_WB : ST_GRANT;
               end
            end
            ST_WB: begin
               if (wb_ready)
                  r_state <= ST_GRANT;
            end
            ST_GRANT: begin
               if (gnt_ready)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == ST_IDLE) && !touch_valid;
   assign wb_valid  = (r_state == ST_WB);
   assign wb_way    = r_way;
   assign gnt_valid = (r_state == ST_GRANT);
   assign gnt_way   = r_way;

endmodule

`default_nettype wire

// File: tb/tb_plru_victim_alloc.sv
// ============================================================================
// tb_plru_victim_alloc : directed self-checking bench for plru_victim_alloc
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_plru_victim_alloc;
   import plru_alloc_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] set_valid = '0;
   logic [7:0] set_dirty = '0;
   logic [7:0] lock_mask = '0;
   logic       touch_valid = 1'b0;
   logic [2:0] touch_way = '0;
   logic       wb_valid;
   logic [2:0] wb_way;
   logic       wb_ready = 1'b1;
   logic       gnt_valid;
   logic [2:0] gnt_way;
   logic       gnt_fail;
   logic       gnt_ready = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int en_cnt  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dut.w_plru_en === 1'b1)
         en_cnt++;
   end

   plru_victim_alloc #(.WAYS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .set_valid   (set_valid),
      .set_dirty   (set_dirty),
      .lock_mask   (lock_mask),
      .touch_valid (touch_valid),
      .touch_way   (touch_way),
      .wb_valid    (wb_valid),
      .wb_way      (wb_way),
      .wb_ready    (wb_ready),
      .gnt_valid   (gnt_valid),
      .gnt_way     (gnt_way),
      .gnt_fail    (gnt_fail),
      .gnt_ready   (gnt_ready)
   );

   task automatic do_reset();
      reset       = 1'b1;
      req_valid   = 1'b0;
      touch_valid = 1'b0;
      lock_mask   = '0;
      wb_ready    = 1'b1;
      gnt_ready   = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Stimulus only: issues one request from IDLE at a negedge, auto-accepts
   // writeback and grant, and reports what it observed.
   task automatic run_alloc(input logic [7:0] v, input logic [7:0] d,
                            input logic [7:0] lk, output logic [2:0] way,
                            output logic fail, output int lat,
                            output logic saw_wb, output logic timeout);
      req_valid = 1'b1;
      set_valid = v;
      set_dirty = d;
      lock_mask = lk;
      @(negedge clk);
      req_valid = 1'b0;
      lat       = 1;
      saw_wb    = 1'b0;
      while (!gnt_valid && lat < 20) begin
         if (wb_valid) saw_wb = 1'b1;
         @(negedge clk);
         lat++;
      end
      timeout   = !gnt_valid;
      way       = gnt_way;
      fail      = gnt_fail;
      gnt_ready = 1'b1;
      @(negedge clk);
      gnt_ready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
      n_tests++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_valid got=%b exp=0", gnt_valid); end
      n_tests++; if (gnt_fail !== 1'b0) begin n_fail++; $display("FAIL reset_gnt_fail got=%b exp=0", gnt_fail); end
      n_tests++; if (gnt_way !== 3'd0) begin n_fail++; $display("FAIL reset_gnt_way got=%0d exp=0", gnt_way); end
      n_tests++; if (wb_way !== 3'd0) begin n_fail++; $display("FAIL reset_wb_way got=%0d exp=0", wb_way); end
      n_tests++; if (dut.u_plru.r_tree !== 7'd0) begin n_fail++; $display("FAIL reset_tree got=%b exp=0", dut.u_plru.r_tree); end
      n_tests++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
   endtask

   task automatic test_free_way();
      logic [2:0] way; logic fail, wb, to; int lat;
      do_reset();
      run_alloc(8'b1111_0111, 8'hFF, 8'h00, way, fail, lat, wb, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL free_timeout got=%b exp=0", to); end
      n_tests++; if (way !== 3'd3) begin n_fail++; $display("FAIL free_way got=%0d exp=3", way); end
      n_tests++; if (wb !== 1'b0) begin n_fail++; $display("FAIL free_no_wb got=%b exp=0", wb); end
      n_tests++; if (lat != 2) begin n_fail++; $display("FAIL free_latency got=%0d exp=2", lat); end
   endtask

   task automatic test_dirty_wb();
      int base;
      do_reset();
      base      = en_cnt;
      wb_ready  = 1'b0;
      req_valid = 1'b1;
      set_valid = 8'hFF;
      set_dirty = 8'hFF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (wb_valid !== 1'b1 || wb_way !== 3'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_hold[%0d] got wb_valid=%b wb_way=%0d gnt_valid=%b exp 1/0/0", i, wb_valid, wb_way, gnt_valid);
         end
         @(negedge clk);
      end
      wb_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (gnt_valid !== 1'b1 || gnt_way !== 3'd0) begin n_fail++; $display("FAIL wb_grant got valid=%b way=%0d exp 1/0", gnt_valid, gnt_way); end
      n_tests++; if (en_cnt - base != 0) begin n_fail++; $display("FAIL wb_no_early_update got=%0d exp=0", en_cnt - base); end
      gnt_ready = 1'b1;
      @(negedge clk);
      gnt_ready = 1'b0;
      @(negedge clk);
      n_tests++; if (en_cnt - base != 1) begin n_fail++; $display("FAIL wb_update_pulses got=%0d exp=1", en_cnt - base); end
      n_tests++; if (dut.u_plru.r_tree !== 7'b000_1011) begin n_fail++; $display("FAIL wb_tree got=%b exp=0001011", dut.u_plru.r_tree); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_seq [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      logic [2:0] way; logic fail, wb, to; int lat;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         run_alloc(8'hFF, 8'h00, 8'h00, way, fail, lat, wb, to);
         n_tests++;
         if (to !== 1'b0 || way !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL b2b_seq[%0d] got=%0d exp=%0d timeout=%b", i, way, exp_seq[i], to);
         end
      end
   endtask

   task automatic test_touch();
      logic [2:0] way; logic fail, wb, to; int lat;
      do_reset();
      touch_valid = 1'b1;
      touch_way   = 3'd0;
      req_valid   = 1'b1;
      set_valid   = 8'hFF;
      set_dirty   = 8'h00;
      #1;
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL touch_stall got=%b exp=0", req_ready); end
      @(negedge clk);
      touch_valid = 1'b0;
      n_tests++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL touch_not_accepted state=%0d exp=%0d", dut.r_state, ST_IDLE); end
      run_alloc(8'hFF, 8'h00, 8'h00, way, fail, lat, wb, to);
      n_tests++; if (to !== 1'b0 || way !== 3'd4) begin n_fail++; $display("FAIL touch_next_way got=%0d exp=4", way); end
   endtask

   task automatic test_lock();
      logic [2:0] way; logic fail, wb, to; int lat; int base;
      do_reset();
      base = en_cnt;
      run_alloc(8'hFF, 8'h00, 8'hFF, way, fail, lat, wb, to);
`ifdef PLRU_ALLOC_LOCK_EN
      n_tests++; if (fail !== 1'b1 || way !== 3'd0) begin n_fail++; $display("FAIL lock_all got fail=%b way=%0d exp 1/0", fail, way); end
      n_tests++; if (en_cnt - base != 0 || dut.u_plru.r_tree !== 7'd0) begin n_fail++; $display("FAIL lock_all_no_update got=%0d tree=%b exp 0", en_cnt - base, dut.u_plru.r_tree); end
      run_alloc(8'hFF, 8'h00, 8'h0F, way, fail, lat, wb, to);
      n_tests++; if (to !== 1'b0 || fail !== 1'b0 || way < 3'd4) begin n_fail++; $display("FAIL lock_low got way=%0d fail=%b exp way in 4..7", way, fail); end
`else
      n_tests++; if (fail !== 1'b0 || way !== 3'd0) begin n_fail++; $display("FAIL lock_ignored got fail=%b way=%0d exp 0/0", fail, way); end
      n_tests++; if (en_cnt - base != 1) begin n_fail++; $display("FAIL lock_ignored_update got=%0d exp=1", en_cnt - base); end
`endif
   endtask

   task automatic test_reset_in_wb();
      logic [2:0] way; logic fail, wb, to; int lat;
      do_reset();
      run_alloc(8'hFF, 8'h00, 8'h00, way, fail, lat, wb, to);
      n_tests++; if (dut.u_plru.r_tree === 7'd0) begin n_fail++; $display("FAIL rwb_tree_pre got=%b exp nonzero", dut.u_plru.r_tree); end
      wb_ready  = 1'b0;
      req_valid = 1'b1;
      set_valid = 8'hFF;
      set_dirty = 8'hFF;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (wb_valid !== 1'b1 || wb_way !== 3'd4) begin n_fail++; $display("FAIL rwb_in_wb got valid=%b way=%0d exp 1/4", wb_valid, wb_way); end
      reset = 1'b1;
      @(negedge clk);
      n_tests++; if (dut.r_state !== ST_IDLE) begin n_fail++; $display("FAIL rwb_state got=%0d exp=%0d", dut.r_state, ST_IDLE); end
      n_tests++; if (wb_valid !== 1'b0 || gnt_valid !== 1'b0) begin n_fail++; $display("FAIL rwb_outputs got wb=%b gnt=%b exp 0/0", wb_valid, gnt_valid); end
      n_tests++; if (dut.u_plru.r_tree !== 7'd0) begin n_fail++; $display("FAIL rwb_tree got=%b exp=0", dut.u_plru.r_tree); end
      reset    = 1'b0;
      wb_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_free_way();
      test_dirty_wb();
      test_back_to_back();
      test_touch();
      test_lock();
      test_reset_in_wb();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/plru_victim_alloc.md
PLRU_VICTIM_ALLOC -- requirements
Module: plru_victim_alloc

Interface
REQ-001 SHALL have parameter WAYS, default 8, meaning ways per set; power of two, 2 to 32.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have req_valid  input  1  allocation request (miss fill) for the current set.
REQ-005 SHALL have req_ready  output  1  request accepted when req_valid & req_ready.
REQ-006 SHALL have set_valid  input  WAYS  per-way valid bits of the set, sampled on req accept.
REQ-007 SHALL have set_dirty  input  WAYS  per-way dirty bits of the set, sampled on req accept.
REQ-008 SHALL have lock_mask  input  WAYS  1 = way not allocatable.
REQ-009 SHALL have touch_valid  input  1  hit touch; marks touch_way most-recently-used.
REQ-010 SHALL have touch_way  input  log2(WAYS)  way index for the touch.
REQ-011 SHALL have wb_valid  output  1  writeback request for the dirty victim.
REQ-012 SHALL have wb_way  output  log2(WAYS)  victim way to write back.
REQ-013 SHALL have wb_ready  input  1  writeback accepted.
REQ-014 SHALL have gnt_valid  output  1  allocation result valid.
REQ-015 SHALL have gnt_way  output  log2(WAYS)  allocated way.
REQ-016 SHALL have gnt_fail  output  1  no allocatable way exists; gnt_way is 0.
REQ-017 SHALL have gnt_ready  input  1  consumer accepts the grant.

Function
REQ-018 SHALL implement FSM IDLE -> SELECT -> (WB) -> GRANT -> IDLE.
REQ-019 IDLE: req_ready=1 only when touch_valid=0; if touch_valid=1, the touch updates PLRU that cycle and the request stalls.
REQ-020 On accept, SHALL register set_valid and set_dirty, then enter SELECT.
REQ-021 SELECT (1 cycle) SHALL choose the lowest-index way that is invalid and unlocked, if one exists.
REQ-022 Otherwise SELECT SHALL take the PLRU victim, computed with the evictable mask ~lock_mask.
REQ-023 If lock_mask is all ones, SELECT SHALL set the fail flag and go to GRANT.
REQ-024 A victim that is valid and dirty SHALL cause a transition to WB; otherwise the FSM goes to GRANT.
REQ-025 WB: wb_valid=1 and wb_way stable until wb_ready; on the handshake, go to GRANT.
REQ-026 GRANT: gnt_valid=1 and gnt_way/gnt_fail stable until gnt_ready; on the handshake, return to IDLE.
REQ-027 PLRU update SHALL occur only on the GRANT handshake (when not fail) or on an IDLE touch.
REQ-028 An update SHALL assert the PLRU enable for exactly one cycle, with the evictable mask set to onehot(target way).
REQ-029 Touches outside IDLE SHALL be ignored (no queueing).
REQ-030 Minimum latency from accept to gnt_valid SHALL be 2 cycles (clean victim), or 3 plus writeback wait (dirty victim).
REQ-031 Captured victim and flags SHALL NOT change when lock_mask changes after SELECT.

Reset
REQ-032 On reset: FSM=IDLE, PLRU tree all zeros, wb_valid=0, gnt_valid=0, gnt_fail=0, gnt_way=0, wb_way=0, req_ready=1.
REQ-033 Reset asserted mid-operation SHALL abandon the pending WB or GRANT with no PLRU update; outputs reach reset values after the next edge.

Configuration
REQ-034 With macro PLRU_ALLOC_LOCK_EN defined, lock_mask SHALL behave as specified.
REQ-035 Without PLRU_ALLOC_LOCK_EN, lock_mask SHALL be ignored (treated as all zeros), and gnt_fail SHALL be tied to 0.

Structure
REQ-036 Package plru_alloc_pkg SHALL hold the FSM state enum and the way-index width helper.
REQ-037 SHALL instantiate exactly one sub-module, the existing plru (WAYS passed through, reset_n driven by ~reset).

Verification
REQ-038 Test 1: reset; set_valid=8'b1111_0111, lock=0 -> gnt_way=3, no wb, gnt 2 cycles after accept.
REQ-039 Test 2: all valid, dirty, PLRU fresh after reset -> wb_way=0; hold wb_ready=0 for 5 cycles -> wb stable; then gnt_way=0 and PLRU enable pulses once.
REQ-040 Test 3: all valid, clean, eight back-to-back allocs, gnt_ready=1 -> gnt_way sequence 0,4,2,6,1,5,3,7.
REQ-041 Test 4: touch_valid with req_valid in IDLE, touch_way=0 -> req_ready=0 that cycle; the next alloc (all valid) grants way 4.
REQ-042 Test 5 (PLRU_ALLOC_LOCK_EN): lock_mask=8'hFF -> gnt_fail=1, gnt_way=0, no PLRU update; lock_mask=8'h0F, all valid -> gnt_way is in 4..7.
REQ-043 Test 6: reset asserted in WB -> next cycle FSM is IDLE, wb_valid=0, PLRU tree is 0.
